// File: rtl/binary_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with results held until the next accepted start.
module binary_divider #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_q;
  logic [M:0]   r_r;
  logic [M-1:0] r_d;
  logic [CW-1:0] r_cnt;
  logic         r_busy;
  logic         r_done;
  logic         r_dbz;
  logic [N-1:0] r_quot;
  logic [M-1:0] r_rem;

  logic [M+1:0] w_shift;
  logic [M:0]   w_diff;
  logic         w_fits;
  logic [N-1:0] w_q_next;
  logic [M:0]   w_r_next;
  logic [CW-1:0] w_cnt_next;

  // One restoring step: shift {R,Q} left, trial-subtract D, keep the result if it fits.
  always_comb begin
    w_shift    = {r_r, r_q[N-1]};
    w_fits     = (w_shift >= {2'b00, r_d});
    w_diff     = w_shift[M:0] - {1'b0, r_d};
    w_q_next   = {r_q[N-2:0], w_fits};
    w_r_next   = w_fits ? w_diff : w_shift[M:0];
    w_cnt_next = r_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= CW'(N);
            r_dbz <= 1'b0;
            // A zero divisor skips the iterations and reports a saturated quotient.
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= '0;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= w_cnt_next;
          if (w_cnt_next == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_rem   <= w_r_next[M-1:0];
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/binary_divider.md
# binary_divider

Sequential unsigned integer divider: the inverse of the team's combinational binary multiplier. Given an N-bit dividend and an M-bit divisor, it produces an N-bit quotient and M-bit remainder by restoring division, one quotient bit per clock. It sits beside the multiplier in the ALU datapath behind a start/done handshake, so a multi-cycle operation can be issued and polled by a controller.

## Interface
- N, default 4: dividend and quotient width (N >= 2)
- M, default 2: divisor and remainder width (1 <= M <= N)
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request a division; sampled only in IDLE
- dividend  input  N  unsigned dividend, captured when start is accepted
- divisor  input  M  unsigned divisor, captured when start is accepted
- busy  output  1  high while a division is in progress (state CALC)
- done  output  1  one-cycle pulse: quotient/remainder/div_by_zero are valid
- quotient  output  N  dividend / divisor
- remainder  output  M  dividend % divisor
- div_by_zero  output  1  result was produced for divisor == 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 at a rising edge accepts the request: latch dividend into shift register Q, divisor into D, clear partial remainder R (M+1 bits), load iteration counter with N, clear div_by_zero. If divisor == 0, go to DONE instead of CALC, with quotient = all ones, remainder = 0, div_by_zero = 1. Otherwise go to CALC.
- CALC, each edge: shift {R,Q} left one bit; T = R - {1'b0,D}; if T is non-negative, R = T and Q[0] = 1, else Q[0] = 0; decrement counter. On the edge where the counter reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start during DONE or CALC is ignored (not queued).
- quotient = Q, remainder = R[M-1:0]; both, plus div_by_zero, hold their values from DONE until the next accepted start.
- Operand inputs are don't-care after the accept edge; mid-operation changes have no effect.
- All arithmetic unsigned; R never exceeds M+1 bits; remainder < divisor always.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Applies mid-CALC or in DONE; the in-flight operation is discarded, no done pulse.
- Start accepted at edge E0. Nonzero divisor: busy=1 from after E0 through edge EN; done=1 in the cycle after EN (N cycles after E0); busy=0 in that cycle.
- Zero divisor: done=1 in the cycle after E0; busy never asserts.
- Earliest next accept: edge after the done cycle (IDLE). Throughput: one division per N+2 cycles.
- busy and done are never high together.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic (N=4, M=2): start with 13 / 3 -> busy 4 cycles, done pulses 4 cycles after accept edge, quotient=4, remainder=1, div_by_zero=0.
- Edges: 15 / 1 -> quotient=15, remainder=0; 0 / 3 -> quotient=0, remainder=0; 2 / 3 -> quotient=0, remainder=2.
- Divide by zero: 9 / 0 -> done one cycle after accept, busy never high, quotient=4'b1111, remainder=0, div_by_zero=1; next 6 / 2 -> div_by_zero=0, quotient=3, remainder=0.
- Handshake robustness: accept 14 / 3, then drive start=1 with 5 / 1 and toggle operand buses throughout CALC and DONE -> single done pulse, quotient=4, remainder=2; no second operation started.
- Reset mid-op: accept 11 / 2, drop rst_n for one edge during CALC -> next cycle busy=0, done=0, all outputs 0, no done pulse; then 7 / 2 -> quotient=3, remainder=1.
- Sweep: all 64 pairs for N=4, M=2 against dividend/divisor and dividend%divisor (divisor 0 per rule above); N=8, M=4: 255 / 15 -> quotient=17, remainder=0, done 8 cycles after accept.
